rv32_exec_ctrl: RTL and testbench

- Combined control FSM, datapath muxing and ALU for the multi-cycle RV32I core.
- Sits between an external register file, an external program counter, and the core's registered APB master outputs (paddr/pdata registers live in the parent).
- Sequences instruction fetch, decode, execute and load/store over APB.
- Produces register write-back data and the next PC.

---
 rtl/rv32_exec_ctrl_pkg.sv | 50 +++++
 rtl/rv32_exec_alu.sv | 53 +++++
 rtl/rv32_exec_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_rv32_exec_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_exec_ctrl_pkg.sv
// rtl/rv32_exec_ctrl_pkg.sv - shared encodings for the RV32I execute controller
package rv32_exec_ctrl_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;
   localparam logic [2:0] F3_LB   = 3'b000;
   localparam logic [2:0] F3_LH   = 3'b001;
   localparam logic [2:0] F3_LW   = 3'b010;
   localparam logic [2:0] F3_LBU  = 3'b100;
   localparam logic [2:0] F3_LHU  = 3'b101;
   localparam logic [2:0] F3_SR   = 3'b101;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SLL  = 4'b0001,
      ALU_SLT  = 4'b0010,
      ALU_SLTU = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_OR   = 4'b0110,
      ALU_AND  = 4'b0111,
      ALU_SUB  = 4'b1000,
      ALU_SRA  = 4'b1101
   } alu_op_e;

   typedef enum logic [2:0] {
      ST_FETCH0,
      ST_F_SETUP,
      ST_F_ACCESS,
      ST_EXEC,
      ST_M_SETUP,
      ST_M_ACCESS,
      ST_HALT
   } state_e;

endpackage

// File: rtl/rv32_exec_alu.sv
// rtl/rv32_exec_alu.sv - combinational RV32I ALU with branch compare flag
module rv32_exec_alu
   import rv32_exec_ctrl_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result,
   output logic        cmp_flag
);

   logic [4:0] shamt;
   logic       eq;
   logic       lt;
   logic       ltu;

   assign shamt = b[4:0];
   assign eq    = (a == b);
   assign lt    = ($signed(a) < $signed(b));
   assign ltu   = (a < b);

   always_comb begin
      result = '0;
      case (alu_op_e'(op))
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_SLL:  result = a << shamt;
         ALU_SLT:  result = {31'b0, lt};
         ALU_SLTU: result = {31'b0, ltu};
         ALU_XOR:  result = a ^ b;
         ALU_SRL:  result = a >> shamt;
         ALU_SRA:  result = $signed(a) >>> shamt;
         ALU_OR:   result = a | b;
         ALU_AND:  result = a & b;
         default:  result = '0;
      endcase
   end

   // op[2:0] doubles as the branch funct3 so branches reuse the same operands
   always_comb begin
      cmp_flag = 1'b0;
      case (op[2:0])
         F3_BEQ:  cmp_flag = eq;
         F3_BNE:  cmp_flag = !eq;
         F3_BLT:  cmp_flag = lt;
         F3_BGE:  cmp_flag = !lt;
         F3_BLTU: cmp_flag = ltu;
         F3_BGEU: cmp_flag = !ltu;
         default: cmp_flag = 1'b0;
      endcase
   end

endmodule

// File: rtl/rv32_exec_ctrl.sv
// rtl/rv32_exec_ctrl.sv - multi-cycle RV32I control FSM, datapath muxing and write-back
module rv32_exec_ctrl
   import rv32_exec_ctrl_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            APB_PCLK,
   input  logic            APB_PRESET,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] paddr,
   input  logic [XLEN-1:0] prdata,
   input  logic            pready,
   input  logic            perr,
   input  logic [XLEN-1:0] rs0,
   input  logic [XLEN-1:0] rs1,
   output logic [XLEN-1:0] instruction,
   output logic            psel,
   output logic            penable,
   output logic            pwrite,
   output logic            load_paddr,
   output logic [XLEN-1:0] paddr_val,
   output logic            load_pdata,
   output logic [XLEN-1:0] pdata_val,
   output logic            write_reg,
   output logic [XLEN-1:0] reg_wdata,
   output logic            load_pc,
   output logic [XLEN-1:0] pc_next,
   output logic            halted
);

   state_e          state;
   state_e          state_next;
   logic [XLEN-1:0] instr_q;
   logic            fetch_done;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            rd_nz;
   logic            is_store;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] pc_next_raw;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] load_shifted;
   logic [XLEN-1:0] load_data;

   logic [3:0]      alu_op;
   logic [XLEN-1:0] alu_b;
   logic [XLEN-1:0] alu_result;
   logic            cmp_flag;
   logic            unused_bits;

   assign fetch_done  = (state == ST_F_ACCESS) && pready;
   assign instruction = fetch_done ? prdata : instr_q;

   assign opcode   = instr_q[6:0];
   assign funct3   = instr_q[14:12];
   assign rd_nz    = (instr_q[11:7] != 5'd0);
   assign is_store = (opcode == OPC_STORE);

   assign imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
   assign imm_s = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
   assign imm_b = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
   assign imm_u = {instr_q[31:12], 12'b0};
   assign imm_j = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

   assign pc_plus4     = pc + 32'd4;
   assign mem_addr     = rs0 + (is_store ? imm_s : imm_i);
   assign load_shifted = prdata >> {paddr[1:0], 3'b000};
   assign pc_next      = {pc_next_raw[31:2], 2'b00};
   assign unused_bits  = ^{perr, paddr[31:2], pc_next_raw[1:0]};

   // Only shift-right immediates carry instr[30] into the op; SUB is register-form only
   always_comb begin
      alu_b  = rs1;
      alu_op = {1'b0, funct3};
      if (opcode == OPC_OP) begin
         alu_op = {instr_q[30], funct3};
      end else if (opcode == OPC_OP_IMM) begin
         alu_b  = imm_i;
         alu_op = {(funct3 == F3_SR) & instr_q[30], funct3};
      end
   end

   rv32_exec_alu u_alu (
      .op       (alu_op),
      .a        (rs0),
      .b        (alu_b),
      .result   (alu_result),
      .cmp_flag (cmp_flag)
   );

   always_comb begin
      load_data = load_shifted;
      case (funct3)
         F3_LB:   load_data = {{24{load_shifted[7]}}, load_shifted[7:0]};
         F3_LH:   load_data = {{16{load_shifted[15]}}, load_shifted[15:0]};
         F3_LBU:  load_data = {24'b0, load_shifted[7:0]};
         F3_LHU:  load_data = {16'b0, load_shifted[15:0]};
         F3_LW:   load_data = load_shifted;
         default: load_data = load_shifted;
      endcase
   end

   always_ff @(posedge APB_PCLK) begin
      if (APB_PRESET) begin
         state   <= ST_FETCH0;
         instr_q <= '0;
      end else begin
         state <= state_next;
         if (fetch_done) begin
            instr_q <= prdata;
         end
      end
   end

   always_comb begin
      state_next  = state;
      psel        = 1'b0;
      penable     = 1'b0;
      pwrite      = 1'b0;
      load_paddr  = 1'b0;
      paddr_val   = pc;
      load_pdata  = 1'b0;
      pdata_val   = rs1 << {mem_addr[1:0], 3'b000};
      write_reg   = 1'b0;
      reg_wdata   = alu_result;
      load_pc     = 1'b0;
      pc_next_raw = pc_plus4;
      halted      = 1'b0;
      case (state)
         ST_FETCH0: begin
            load_paddr = 1'b1;
            state_next = ST_F_SETUP;
         end
         ST_F_SETUP: begin
            psel       = 1'b1;
            state_next = ST_F_ACCESS;
         end
         ST_F_ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
            if (pready) begin
               state_next = (prdata == '0) ? ST_HALT : ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_next = ST_FETCH0;
            load_pc    = 1'b1;
            write_reg  = rd_nz;
            case (opcode)
               OPC_OP, OPC_OP_IMM: reg_wdata = alu_result;
               OPC_LUI:   reg_wdata = imm_u;
               OPC_AUIPC: reg_wdata = pc + imm_u;
               OPC_JAL: begin
                  reg_wdata   = pc_plus4;
                  pc_next_raw = pc + imm_j;
               end
               OPC_JALR: begin
                  reg_wdata   = pc_plus4;
                  pc_next_raw = (rs0 + imm_i) & ~32'd1;
               end
               OPC_BRANCH: begin
                  write_reg = 1'b0;
                  if (cmp_flag) begin
                     pc_next_raw = pc + imm_b;
                  end
               end
               OPC_LOAD, OPC_STORE: begin
                  load_pc    = 1'b0;
                  write_reg  = 1'b0;
                  load_paddr = 1'b1;
                  paddr_val  = mem_addr;
                  load_pdata = is_store;
                  state_next = ST_M_SETUP;
               end
               default: begin
                  load_pc    = 1'b0;
                  write_reg  = 1'b0;
                  state_next = ST_HALT;
               end
            endcase
         end
         ST_M_SETUP: begin
            psel       = 1'b1;
            pwrite     = is_store;
            state_next = ST_M_ACCESS;
         end
         ST_M_ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
            pwrite  = is_store;
            if (pready) begin
               load_pc    = 1'b1;
               write_reg  = rd_nz && (opcode == OPC_LOAD);
               reg_wdata  = load_data;
               state_next = ST_FETCH0;
            end
         end
         ST_HALT: begin
            halted = 1'b1;
         end
         default: state_next = ST_FETCH0;
      endcase
   end

endmodule

// File: tb/tb_rv32_exec_ctrl.sv
// tb/tb_rv32_exec_ctrl.sv - self-checking bench for rv32_exec_ctrl
module tb_rv32_exec_ctrl;

   typedef enum {K_ALU, K_LOAD, K_STORE, K_HALT} kind_e;

   typedef struct {
      kind_e       kind;
      logic        wr;
      logic [31:0] wdata;
      logic [31:0] pcn;
      logic [31:0] addr;
      logic [31:0] sdata;
   } exp_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] md;
      int          mw;
      kind_e       kind;
      logic        wr;
      logic [31:0] wdata;
      logic [31:0] pcn;
      logic [31:0] addr;
      logic [31:0] sdata;
   } vec_t;

   logic        clk = 1'b0;
   logic        APB_PRESET;
   logic [31:0] pc, paddr, prdata, rs0, rs1;
   logic        pready, perr;
   logic [31:0] instruction, paddr_val, pdata_val, reg_wdata, pc_next;
   logic        psel, penable, pwrite, load_paddr, load_pdata, write_reg, load_pc, halted;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rv32_exec_ctrl dut (
      .APB_PCLK    (clk),
      .APB_PRESET  (APB_PRESET),
      .pc          (pc),
      .paddr       (paddr),
      .prdata      (prdata),
      .pready      (pready),
      .perr        (perr),
      .rs0         (rs0),
      .rs1         (rs1),
      .instruction (instruction),
      .psel        (psel),
      .penable     (penable),
      .pwrite      (pwrite),
      .load_paddr  (load_paddr),
      .paddr_val   (paddr_val),
      .load_pdata  (load_pdata),
      .pdata_val   (pdata_val),
      .write_reg   (write_reg),
      .reg_wdata   (reg_wdata),
      .load_pc     (load_pc),
      .pc_next     (pc_next),
      .halted      (halted)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Architectural reference: what an RV32I instruction should produce
   function automatic exp_t model(input logic [31:0] ins, pcv, a, b, md);
      exp_t        e;
      logic [31:0] ii, is, ib, ij, u, bv, r, d;
      logic [2:0]  f3;
      logic        taken;
      ii = 32'($signed(ins[31:20]));
      is = 32'($signed({ins[31:25], ins[11:7]}));
      ib = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      ij = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      u  = {ins[31:12], 12'h000};
      f3 = ins[14:12];
      e  = '{K_ALU, (ins[11:7] != 5'd0), 32'h0, pcv + 32'd4, 32'h0, 32'h0};
      case (ins[6:0])
         7'h33, 7'h13: begin
            bv = (ins[6:0] == 7'h33) ? b : ii;
            case (f3)
               3'd0: r = (ins[6:0] == 7'h33 && ins[30]) ? a - bv : a + bv;
               3'd1: r = a << bv[4:0];
               3'd2: r = ($signed(a) < $signed(bv)) ? 32'd1 : 32'd0;
               3'd3: r = (a < bv) ? 32'd1 : 32'd0;
               3'd4: r = a ^ bv;
               3'd5: r = ins[30] ? 32'($signed(a) >>> bv[4:0]) : a >> bv[4:0];
               3'd6: r = a | bv;
               default: r = a & bv;
            endcase
            e.wdata = r;
         end
         7'h37: e.wdata = u;
         7'h17: e.wdata = pcv + u;
         7'h6F: begin e.wdata = pcv + 32'd4; e.pcn = pcv + ij; end
         7'h67: begin e.wdata = pcv + 32'd4; e.pcn = a + ii; end
         7'h63: begin
            case (f3)
               3'd0: taken = (a == b);
               3'd1: taken = (a != b);
               3'd4: taken = ($signed(a) < $signed(b));
               3'd5: taken = ($signed(a) >= $signed(b));
               3'd6: taken = (a < b);
               default: taken = (a >= b);
            endcase
            e.wr = 1'b0;
            if (taken) e.pcn = pcv + ib;
         end
         7'h03: begin
            e.kind = K_LOAD;
            e.addr = a + ii;
            d = md >> (8 * e.addr[1:0]);
            case (f3)
               3'd0: e.wdata = 32'($signed(d[7:0]));
               3'd1: e.wdata = 32'($signed(d[15:0]));
               3'd4: e.wdata = d & 32'hFF;
               3'd5: e.wdata = d & 32'hFFFF;
               default: e.wdata = d;
            endcase
         end
         7'h23: begin
            e.kind  = K_STORE;
            e.wr    = 1'b0;
            e.addr  = a + is;
            e.sdata = b << (8 * e.addr[1:0]);
         end
         default: begin e.kind = K_HALT; e.wr = 1'b0; end
      endcase
      e.pcn = e.pcn & ~32'd3;
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      logic [2:0]  f3;
      logic        alt;
      int          s;
      r   = $urandom;
      alt = r[30];
      f3  = r[14:12];
      s   = $urandom_range(0, 8);
      case (s)
         0: begin r[31:25] = ((f3 == 3'd0 || f3 == 3'd5) && alt) ? 7'h20 : 7'h00; r[6:0] = 7'h33; end
         1: begin
            if (f3 == 3'd1) r[31:25] = 7'h00;
            if (f3 == 3'd5) r[31:25] = alt ? 7'h20 : 7'h00;
            r[6:0] = 7'h13;
         end
         2: r[6:0] = 7'h37;
         3: r[6:0] = 7'h17;
         4: r[6:0] = 7'h6F;
         5: begin r[14:12] = 3'd0; r[6:0] = 7'h67; end
         6: begin
            s = $urandom_range(0, 5);
            r[14:12] = (s < 2) ? 3'(s) : 3'(s + 2);
            r[6:0] = 7'h63;
         end
         7: begin
            s = $urandom_range(0, 4);
            r[14:12] = (s == 3) ? 3'd4 : (s == 4) ? 3'd5 : 3'(s);
            r[6:0] = 7'h03;
         end
         default: begin r[14:12] = 3'($urandom_range(0, 2)); r[6:0] = 7'h23; end
      endcase
      return r;
   endfunction

   // Drives one full instruction from FETCH0 and checks every cycle until the next FETCH0
   task automatic run_instr(input logic [31:0] ins, pcv, a, b, md, input int fw, mw, input exp_t e);
      logic [31:0] nxt;
      logic        pw;
      pc = pcv; rs0 = a; rs1 = b; pready = 1'b1; prdata = $urandom; perr = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("fetch0_load_paddr", 32'(load_paddr), 32'd1);
      chk("fetch0_paddr_val", paddr_val, pcv);
      chk("fetch0_apb_idle", 32'({psel, penable, load_pc, write_reg}), 32'd0);
      chk("fetch0_halted", 32'(halted), 32'd0);
      step();
      @(negedge clk);
      chk("fsetup_ctrl", 32'({psel, penable, pwrite}), 32'b100);
      step();
      for (int i = 0; i < fw; i++) begin
         pready = 1'b0; prdata = $urandom;
         @(negedge clk);
         chk("faccess_wait_ctrl", 32'({psel, penable, load_pc}), 32'b110);
         step();
      end
      pready = 1'b1; prdata = ins;
      @(negedge clk);
      chk("faccess_ctrl", 32'({psel, penable, pwrite}), 32'b110);
      chk("fetch_instruction", instruction, ins);
      step();
      prdata = $urandom; pready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("exec_instruction", instruction, ins);
      chk("exec_psel", 32'({psel, penable}), 32'd0);
      if (e.kind == K_ALU) begin
         chk("exec_load_pc", 32'(load_pc), 32'd1);
         chk("exec_pc_next", pc_next, e.pcn);
         chk("exec_write_reg", 32'(write_reg), 32'(e.wr));
         if (e.wr) chk("exec_reg_wdata", reg_wdata, e.wdata);
         step();
      end else if (e.kind == K_HALT) begin
         chk("exec_halt_strobes", 32'({load_pc, write_reg, load_paddr, load_pdata}), 32'd0);
         step();
      end else begin
         pw = (e.kind == K_STORE);
         chk("exec_load_paddr", 32'(load_paddr), 32'd1);
         chk("exec_paddr_val", paddr_val, e.addr);
         chk("exec_load_pc", 32'({load_pc, write_reg}), 32'd0);
         chk("exec_load_pdata", 32'(load_pdata), 32'(pw));
         if (pw) chk("exec_pdata_val", pdata_val, e.sdata);
         nxt = paddr_val;
         step();
         paddr = nxt;
         @(negedge clk);
         chk("msetup_ctrl", 32'({psel, penable, pwrite}), 32'({2'b10, pw}));
         step();
         for (int i = 0; i < mw; i++) begin
            pready = 1'b0; prdata = $urandom;
            @(negedge clk);
            chk("maccess_wait_ctrl", 32'({psel, penable, pwrite, load_pc, write_reg}), 32'({2'b11, pw, 2'b00}));
            step();
         end
         pready = 1'b1; prdata = md;
         @(negedge clk);
         chk("maccess_ctrl", 32'({psel, penable, pwrite}), 32'({2'b11, pw}));
         chk("maccess_load_pc", 32'(load_pc), 32'd1);
         chk("maccess_pc_next", pc_next, e.pcn);
         chk("maccess_write_reg", 32'(write_reg), 32'(e.wr));
         if (e.wr) chk("maccess_reg_wdata", reg_wdata, e.wdata);
         step();
      end
   endtask

   task automatic check_halted(input string tag);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk({tag, "_halted"}, 32'(halted), 32'd1);
         chk({tag, "_idle"}, 32'({psel, penable, load_paddr, load_pc, write_reg, load_pdata}), 32'd0);
         step();
      end
      APB_PRESET = 1'b1;
      step();
      APB_PRESET = 1'b0;
   endtask

   vec_t        vt [16];
   exp_t        e;
   logic [31:0] ins, pcv, a, b, md;

   initial begin
      vt[0]  = '{32'h00500093, 32'h000, 0, 0, 0, 0, K_ALU, 1'b1, 32'h5, 32'h4, 0, 0};
      vt[1]  = '{32'h402081B3, 32'h010, 3, 5, 0, 0, K_ALU, 1'b1, 32'hFFFFFFFE, 32'h14, 0, 0};
      vt[2]  = '{32'h4020D1B3, 32'h014, 32'h80000000, 4, 0, 0, K_ALU, 1'b1, 32'hF8000000, 32'h18, 0, 0};
      vt[3]  = '{32'hFE208CE3, 32'h020, 7, 7, 0, 0, K_ALU, 1'b0, 0, 32'h18, 0, 0};
      vt[4]  = '{32'hFE209CE3, 32'h020, 7, 7, 0, 0, K_ALU, 1'b0, 0, 32'h24, 0, 0};
      vt[5]  = '{32'h00208283, 32'h030, 32'h1000, 0, 32'h00800000, 3, K_LOAD, 1'b1, 32'hFFFFFF80, 32'h34, 32'h1002, 0};
      vt[6]  = '{32'h0020A223, 32'h040, 32'h100, 32'hDEADBEEF, 0, 1, K_STORE, 1'b0, 0, 32'h44, 32'h104, 32'hDEADBEEF};
      vt[7]  = '{32'h123453B7, 32'h050, 0, 0, 0, 0, K_ALU, 1'b1, 32'h12345000, 32'h54, 0, 0};
      vt[8]  = '{32'h00001397, 32'h100, 0, 0, 0, 0, K_ALU, 1'b1, 32'h1100, 32'h104, 0, 0};
      vt[9]  = '{32'h010000EF, 32'h200, 0, 0, 0, 0, K_ALU, 1'b1, 32'h204, 32'h210, 0, 0};
      vt[10] = '{32'h003100E7, 32'h300, 32'h1000, 0, 0, 0, K_ALU, 1'b1, 32'h304, 32'h1000, 0, 0};
      vt[11] = '{32'h00100013, 32'h060, 0, 0, 0, 0, K_ALU, 1'b0, 0, 32'h64, 0, 0};
      vt[12] = '{32'h0000D283, 32'h070, 32'h2002, 0, 32'hABCD1234, 0, K_LOAD, 1'b1, 32'h0000ABCD, 32'h74, 32'h2002, 0};
      vt[13] = '{32'h002080A3, 32'h080, 32'h200, 32'hA5, 0, 2, K_STORE, 1'b0, 0, 32'h84, 32'h201, 32'h0000A500};
      vt[14] = '{32'hFFF0A193, 32'h090, 32'hFFFFFFFE, 0, 0, 0, K_ALU, 1'b1, 32'h1, 32'h94, 0, 0};
      vt[15] = '{32'h4040D193, 32'h094, 32'h80000000, 0, 0, 0, K_ALU, 1'b1, 32'hF8000000, 32'h98, 0, 0};

      APB_PRESET = 1'b1; pc = 0; paddr = 0; prdata = 0; pready = 1'b1; perr = 1'b0; rs0 = 0; rs1 = 0;
      step();
      @(negedge clk);
      chk("reset_halted", 32'(halted), 32'd0);
      chk("reset_apb", 32'({psel, penable, pwrite, load_pc, write_reg, load_pdata}), 32'd0);
      chk("reset_instruction", instruction, 32'd0);
      chk("reset_load_paddr", 32'(load_paddr), 32'd1);
      step();
      APB_PRESET = 1'b0;

      for (int i = 0; i < 16; i++) begin
         e = '{vt[i].kind, vt[i].wr, vt[i].wdata, vt[i].pcn, vt[i].addr, vt[i].sdata};
         run_instr(vt[i].instr, vt[i].pc, vt[i].a, vt[i].b, vt[i].md, i % 2, vt[i].mw, e);
      end

      // reset while a fetch is stalled in the access phase
      pc = 32'h600; pready = 1'b0;
      step();
      step();
      @(negedge clk);
      chk("mid_faccess", 32'({psel, penable}), 32'b11);
      APB_PRESET = 1'b1;
      step();
      APB_PRESET = 1'b0;
      run_instr(32'h00500093, 32'h600, 0, 0, 0, 0, 0, '{K_ALU, 1'b1, 32'h5, 32'h604, 32'h0, 32'h0});

      // all-zero fetched word halts straight from the access phase
      pc = 32'h400; pready = 1'b1; prdata = 32'h0;
      step();
      step();
      @(negedge clk);
      chk("zero_faccess", 32'({psel, penable}), 32'b11);
      step();
      check_halted("zero");
      run_instr(32'h00500093, 32'h404, 0, 0, 0, 0, 0, '{K_ALU, 1'b1, 32'h5, 32'h408, 32'h0, 32'h0});

      run_instr(32'h00000073, 32'h500, 0, 0, 0, 1, 0, '{K_HALT, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0});
      check_halted("ecall");
      run_instr(32'h00500093, 32'h504, 0, 0, 0, 0, 0, '{K_ALU, 1'b1, 32'h5, 32'h508, 32'h0, 32'h0});

      for (int n = 0; n < 200; n++) begin
         ins = rand_instr();
         pcv = $urandom & 32'hFFFF_FFFC;
         a   = $urandom;
         b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
         md  = $urandom;
         e   = model(ins, pcv, a, b, md);
         run_instr(ins, pcv, a, b, md, $urandom_range(0, 2), $urandom_range(0, 2), e);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
